pong_game: RTL

PONG_GAME -- requirements
Module: pong_game

---
 rtl/pong_game.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pong_game.sv
// Pong core: ball, paddles, scores and serve FSM advance once per frame; colour is generated from that state.
// Colour lags sx/sy by one clk_25 cycle; no backpressure, the raster timing is free-running.
module pong_game #(
    parameter int XRES         = 640,
    parameter int YRES         = 480,
    parameter int VMAX         = 524,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 48,
    parameter int PAD_MARGIN   = 16,
    parameter int PAD_SPEED    = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9,
    parameter int SCORE_W      = 4
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic [9:0]         sx,
    input  logic [9:0]         sy,
    input  logic               active_pixel,
    input  logic               btn_lu,
    input  logic               btn_ld,
    input  logic               btn_ru,
    input  logic               btn_rd,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over
);
    typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;

    localparam logic [10:0] C_XRES  = 11'(XRES);
    localparam logic [10:0] C_YRES  = 11'(YRES);
    localparam logic [10:0] C_BS    = 11'(BALL_SIZE);
    localparam logic [10:0] C_SPD   = 11'(BALL_SPEED);
    localparam logic [10:0] C_PW    = 11'(PAD_W);
    localparam logic [10:0] C_PH    = 11'(PAD_H);
    localparam logic [10:0] C_PM    = 11'(PAD_MARGIN);
    localparam logic [10:0] C_PSPD  = 11'(PAD_SPEED);
    localparam logic [10:0] C_LP    = 11'(PAD_MARGIN + PAD_W);
    localparam logic [10:0] C_RP    = 11'(XRES - PAD_MARGIN - PAD_W);
    localparam logic [10:0] C_BX0   = 11'((XRES - BALL_SIZE) / 2);
    localparam logic [10:0] C_BY0   = 11'((YRES - BALL_SIZE) / 2);
    localparam logic [10:0] C_PY0   = 11'((YRES - PAD_H) / 2);
    localparam logic [10:0] C_PYMAX = 11'(YRES - PAD_H);
    localparam logic [10:0] C_NET0  = 11'(XRES / 2 - 1);
    localparam logic [10:0] C_NET1  = 11'(XRES / 2);

    state_t      state;
    logic [10:0] bx, by, pl_y, pr_y;
    logic        dx_right, dy_down, left_scored;
    logic [15:0] serve_cnt;

    logic        animate, any_btn;
    logic [10:0] px, py;
    logic        ovl_l, ovl_r, miss_l, miss_r, hit_l, hit_r;
    logic [10:0] nbx, nby;
    logic        ndx, ndy;
    logic        in_ball, in_pl, in_pr, in_net;
    logic [11:0] colour;

    function automatic logic [10:0] pad_next(input logic [10:0] y, input logic up, input logic dn);
        logic [10:0] r;
        r = y;
        if (up && !dn)
            r = (y < C_PSPD) ? 11'd0 : y - C_PSPD;
        else if (dn && !up)
            r = (y + C_PSPD > C_PYMAX) ? C_PYMAX : y + C_PSPD;
        return r;
    endfunction

    // Both axes are resolved from the pre-update position, so a corner hit reflects both.
    always_comb begin
        animate = (sy == 10'(VMAX)) && (sx == 10'd0);
        any_btn = btn_lu | btn_ld | btn_ru | btn_rd;
        px      = {1'b0, sx};
        py      = {1'b0, sy};

        ovl_l  = (by + C_BS > pl_y) && (by < pl_y + C_PH);
        ovl_r  = (by + C_BS > pr_y) && (by < pr_y + C_PH);
        miss_l = !dx_right && (bx < C_SPD);
        miss_r = dx_right && (bx + C_BS + C_SPD > C_XRES);
        hit_l  = !dx_right && (bx >= C_LP) && (bx < C_LP + C_SPD) && ovl_l;
        hit_r  = dx_right && (bx + C_BS > C_RP - C_SPD) && (bx + C_BS <= C_RP) && ovl_r;

        nbx = dx_right ? bx + C_SPD : bx - C_SPD;
        ndx = dx_right;
        if (hit_l) begin
            nbx = C_LP;
            ndx = 1'b1;
        end else if (hit_r) begin
            nbx = C_RP - C_BS;
            ndx = 1'b0;
        end

        nby = dy_down ? by + C_SPD : by - C_SPD;
        ndy = dy_down;
        if (!dy_down && (by < C_SPD)) begin
            nby = 11'd0;
            ndy = 1'b1;
        end else if (dy_down && (by + C_BS + C_SPD >= C_YRES)) begin
            nby = C_YRES - C_BS;
            ndy = 1'b0;
        end

        in_ball = (state != GAME_OVER) && (px >= bx) && (px < bx + C_BS)
                  && (py >= by) && (py < by + C_BS);
        in_pl   = (px >= C_PM) && (px < C_LP) && (py >= pl_y) && (py < pl_y + C_PH);
        in_pr   = (px >= C_RP) && (px < C_RP + C_PW) && (py >= pr_y) && (py < pr_y + C_PH);
        in_net  = ((px == C_NET0) || (px == C_NET1)) && !sy[4];

        if (!active_pixel) colour = 12'h000;
        else if (in_ball)  colour = 12'hFFF;
        else if (in_pl)    colour = 12'h0F0;
        else if (in_pr)    colour = 12'h00F;
        else if (in_net)   colour = 12'h888;
        else               colour = 12'h111;
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state       <= SERVE;
            serve_cnt   <= '0;
            bx          <= C_BX0;
            by          <= C_BY0;
            dx_right    <= 1'b1;
            dy_down     <= 1'b1;
            left_scored <= 1'b0;
            pl_y        <= C_PY0;
            pr_y        <= C_PY0;
            score_l     <= '0;
            score_r     <= '0;
            game_over   <= 1'b0;
        end else if (animate) begin
            if (state != GAME_OVER) begin
                pl_y <= pad_next(pl_y, btn_lu, btn_ld);
                pr_y <= pad_next(pr_y, btn_ru, btn_rd);
            end
            case (state)
                SERVE: begin
                    bx <= C_BX0;
                    by <= C_BY0;
                    if (serve_cnt == 16'(SERVE_FRAMES - 1)) begin
                        serve_cnt <= '0;
                        state     <= PLAY;
                    end else begin
                        serve_cnt <= serve_cnt + 16'd1;
                    end
                end
                PLAY: begin
                    if (miss_l || miss_r) begin
                        left_scored <= miss_r;
                        state       <= POINT;
                    end else begin
                        bx       <= nbx;
                        by       <= nby;
                        dx_right <= ndx;
                        dy_down  <= ndy;
                    end
                end
                POINT: begin
                    bx        <= C_BX0;
                    by        <= C_BY0;
                    serve_cnt <= '0;
                    if (left_scored) score_l <= score_l + SCORE_W'(1);
                    else             score_r <= score_r + SCORE_W'(1);
                    if ((left_scored ? score_l : score_r) + SCORE_W'(1) == SCORE_W'(WIN_SCORE)) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state    <= SERVE;
                        dx_right <= left_scored;
                    end
                end
                GAME_OVER: begin
                    if (any_btn) begin
                        score_l   <= '0;
                        score_r   <= '0;
                        state     <= SERVE;
                        game_over <= 1'b0;
                        dx_right  <= 1'b1;
                        bx        <= C_BX0;
                        by        <= C_BY0;
                        serve_cnt <= '0;
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) {vga_r, vga_g, vga_b} <= 12'h000;
        else     {vga_r, vga_g, vga_b} <= colour;
    end
endmodule
